// File: rtl/get_data_pipe_pkg.sv
// get_data_pipe_pkg: position/symbol codes and decode helpers shared by the
// get_data_pipe ROM fetch slice.
package get_data_pipe_pkg;

   localparam int POS_W = 5;

   // Shared position (action) encoding of the search datapath.
   typedef enum logic [POS_W-1:0] {
      POS_NONE         = 5'd0,
      POS_A_INSERTION  = 5'd1,
      POS_C_INSERTION  = 5'd2,
      POS_G_INSERTION  = 5'd3,
      POS_T_INSERTION  = 5'd4,
      POS_A_DELETION   = 5'd5,
      POS_C_DELETION   = 5'd6,
      POS_G_DELETION   = 5'd7,
      POS_T_DELETION   = 5'd8,
      POS_A_MATCH      = 5'd9,
      POS_C_MATCH      = 5'd10,
      POS_G_MATCH      = 5'd11,
      POS_T_MATCH      = 5'd12,
      POS_A_SNP        = 5'd13,
      POS_C_SNP        = 5'd14,
      POS_G_SNP        = 5'd15,
      POS_T_SNP        = 5'd16,
      POS_STOP_SUCCESS = 5'd17,
      POS_STOP_FAIL    = 5'd18
   } pos_e;

   typedef enum logic [1:0] {SYM_A, SYM_C, SYM_G, SYM_T} sym_e;

   // What a position asks of the ROMs.
   typedef enum logic [1:0] {ACT_READ_D, ACT_INS, ACT_DEL, ACT_IDLE} act_e;

   function automatic act_e pos_act(input logic [POS_W-1:0] pos);
      if (pos == POS_NONE) return ACT_READ_D;
      if (pos >= POS_A_INSERTION && pos <= POS_T_INSERTION) return ACT_INS;
      if (pos >= POS_A_DELETION && pos <= POS_T_DELETION) return ACT_DEL;
      return ACT_IDLE;
   endfunction

   // Symbol carried by an insertion/deletion code (groups of four, A..T).
   function automatic logic [1:0] pos_sym(input logic [POS_W-1:0] pos);
      logic [POS_W-1:0] off;
      off = pos - POS_A_INSERTION;
      return off[1:0];
   endfunction

   // LSB of the count lane for a symbol inside a packed Occ word.
   function automatic int lane_lsb(input logic [1:0] sym, input int cnt_w);
      return int'(sym) * cnt_w;
   endfunction

endpackage

// File: rtl/get_data_pipe_if.sv
// get_data_pipe_if: input tuple stream and output tuple+data stream of the
// ROM fetch stage. slave = the fetch stage, master = its environment.
interface get_data_pipe_if #(
   parameter int IDX_W  = 8,
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 8,
   parameter int READ_W = 2
);
   logic              in_valid, in_ready;
   logic [IDX_W-1:0]  i_in, z_in, k_in, l_in;
   logic [ADDR_W-1:0] addr_in;
   logic [4:0]        position_in;

   logic              out_valid, out_ready;
   logic [IDX_W-1:0]  i_out, z_out, k_out, l_out;
   logic [ADDR_W-1:0] addr_out;
   logic [4:0]        position_out;
   logic [CNT_W-1:0]  C_out, data_1_out, data_2_out, d_i_out;
   logic [READ_W-1:0] read_i_out;

   modport slave (
      input  in_valid, i_in, z_in, k_in, l_in, addr_in, position_in, out_ready,
      output in_ready, out_valid, i_out, z_out, k_out, l_out, addr_out, position_out,
      output C_out, data_1_out, data_2_out, d_i_out, read_i_out
   );

   modport master (
      output in_valid, i_in, z_in, k_in, l_in, addr_in, position_in, out_ready,
      input  in_ready, out_valid, i_out, z_out, k_out, l_out, addr_out, position_out,
      input  C_out, data_1_out, data_2_out, d_i_out, read_i_out
   );
endinterface

// File: rtl/get_data_fifo.sv
// get_data_fifo: synchronous show-ahead FIFO with occupancy output.
// Read data is forced to zero while empty so downstream never sees stale words.
module get_data_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic [CW-1:0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PTR_W-1:0]        wr_q, rd_q;
   logic [CW-1:0]           cnt_q;
   logic                    do_pop;

   assign do_pop = pop_i && (cnt_q != '0);

   // Pointers wrap naturally at the power-of-2 depth; count tells full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         case ({push_i, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage array, written at the tail.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/get_data_pipe.sv
// get_data_pipe: issues C/Occ/read_and_D ROM reads for each accepted search
// tuple, carries the tuple alongside the ROM latency and queues tuple+data in
// an output FIFO. Optional macro GET_DATA_K0_GUARD_EN: an insertion with k==0
// reads Occ(-1) as zero instead of the wrapped all-ones address.
module get_data_pipe
   import get_data_pipe_pkg::*;
#(
   parameter int IDX_W      = 8,
   parameter int ADDR_W     = 12,
   parameter int CNT_W      = 8,
   parameter int READ_W     = 2,
   parameter int ROM_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   get_data_pipe_if.slave      bus,
   output logic                ce_rom_C,
   output logic [1:0]          addr_rom_C,
   output logic                ce_rom_Occ,
   output logic [IDX_W-1:0]    addr1_rom_Occ,
   output logic [IDX_W-1:0]    addr2_rom_Occ,
   output logic                ce_rom_read_and_D,
   output logic [IDX_W-1:0]    addr_rom_read_and_D,
   input  logic [CNT_W-1:0]    data_C,
   input  logic [4*CNT_W-1:0]  data_1,
   input  logic [4*CNT_W-1:0]  data_2,
   input  logic [CNT_W-1:0]    d_i,
   input  logic [READ_W-1:0]   read_i
);
   localparam int TUP_W = 4*IDX_W + ADDR_W + POS_W;
   localparam int ENT_W = TUP_W + 4*CNT_W + READ_W;
   localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);

   logic             fire, pop;
   act_e             in_act;
   logic [1:0]       in_sym;
   logic [IDX_W-1:0] k_prev;
   logic [CRD_W-1:0] crd_q, crd_d;

   assign in_act       = pos_act(bus.position_in);
   assign in_sym       = pos_sym(bus.position_in);
   // Credits cover both the ROM pipe and the FIFO, so the FIFO can never overflow.
   assign bus.in_ready = !rst && (crd_q < CRD_W'(FIFO_DEPTH));
   assign fire         = bus.in_valid && bus.in_ready;

`ifdef GET_DATA_K0_GUARD_EN
   assign k_prev = (bus.k_in == '0) ? '0 : bus.k_in - 1'b1;
`else
   assign k_prev = bus.k_in - 1'b1;
`endif

   // ROM request decode; everything idles at zero unless a tuple fires.
   always_comb begin
      ce_rom_C            = 1'b0;
      addr_rom_C          = '0;
      ce_rom_Occ          = 1'b0;
      addr1_rom_Occ       = '0;
      addr2_rom_Occ       = '0;
      ce_rom_read_and_D   = 1'b0;
      addr_rom_read_and_D = '0;
      if (fire) begin
         unique case (in_act)
            ACT_INS: begin
               ce_rom_C      = 1'b1;
               addr_rom_C    = in_sym;
               ce_rom_Occ    = 1'b1;
               addr1_rom_Occ = k_prev;
               addr2_rom_Occ = bus.l_in;
            end
            ACT_READ_D, ACT_DEL: begin
               ce_rom_read_and_D   = 1'b1;
               addr_rom_read_and_D = bus.i_in;
            end
            default: ;
         endcase
      end
   end

   logic [ROM_LAT-1:0]            vld_q;
   logic [ROM_LAT-1:0][TUP_W-1:0] tup_q;

   // Valid shift pipe; cleared by reset so ROM data for flushed tuples is dropped.
   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else begin
         vld_q[0] <= fire;
         for (int s = 1; s < ROM_LAT; s++) vld_q[s] <= vld_q[s-1];
      end
   end

   // Tuple payload travels beside the valids, matching the ROM latency.
   always_ff @(posedge clk) begin
      tup_q[0] <= {bus.i_in, bus.z_in, bus.k_in, bus.l_in, bus.addr_in, bus.position_in};
      for (int s = 1; s < ROM_LAT; s++) tup_q[s] <= tup_q[s-1];
   end

   logic [IDX_W-1:0]  t_i, t_z, t_k, t_l;
   logic [ADDR_W-1:0] t_addr;
   logic [POS_W-1:0]  t_pos;
   logic [CNT_W-1:0]  f_c, f_d1, f_d2, f_di;
   logic [READ_W-1:0] f_rd;

   assign {t_i, t_z, t_k, t_l, t_addr, t_pos} = tup_q[ROM_LAT-1];

   // Keep only the fields the position asked for; the rest are zero.
   always_comb begin
      f_c  = '0;
      f_d1 = '0;
      f_d2 = '0;
      f_di = '0;
      f_rd = '0;
      unique case (pos_act(t_pos))
         ACT_READ_D: f_di = d_i;
         ACT_INS: begin
            f_c  = data_C;
            f_d1 = data_1[lane_lsb(pos_sym(t_pos), CNT_W) +: CNT_W];
            f_d2 = data_2[lane_lsb(pos_sym(t_pos), CNT_W) +: CNT_W];
`ifdef GET_DATA_K0_GUARD_EN
            if (t_k == '0) f_d1 = '0;
`endif
         end
         ACT_DEL: f_rd = read_i;
         default: ;
      endcase
   end

   logic [ENT_W-1:0] fifo_dout;
   logic [FCW-1:0]   fifo_cnt;

   get_data_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (vld_q[ROM_LAT-1]),
      .din_i   ({tup_q[ROM_LAT-1], f_c, f_d1, f_d2, f_di, f_rd}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt)
   );

   assign bus.out_valid = (fifo_cnt != '0);
   assign pop           = bus.out_valid && bus.out_ready;
   assign {bus.i_out, bus.z_out, bus.k_out, bus.l_out, bus.addr_out, bus.position_out,
           bus.C_out, bus.data_1_out, bus.data_2_out, bus.d_i_out, bus.read_i_out} = fifo_dout;

   // Credit next-state: one per accepted tuple, returned on output pop.
   always_comb begin
      crd_d = crd_q;
      case ({fire, pop})
         2'b10:   crd_d = crd_q + 1'b1;
         2'b01:   crd_d = crd_q - 1'b1;
         default: ;
      endcase
   end

   // Credit register.
   always_ff @(posedge clk) begin
      if (rst) crd_q <= '0;
      else     crd_q <= crd_d;
   end
endmodule

// File: tb/tb_get_data_pipe.sv
// tb_get_data_pipe: randomized + directed scoreboard bench for get_data_pipe
// (ROM_LAT=1 main instance, ROM_LAT=3 latency instance).
module tb_get_data_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int checks = 0, errors = 0;
   int n_acc = 0, n_out = 0;

   typedef struct packed {
      logic [7:0]  i, z, k, l;
      logic [11:0] addr;
      logic [4:0]  pos;
      logic [7:0]  c, d1, d2, di;
      logic [1:0]  rd;
   } out_t;

   out_t exp_q[$];

   // ROM contents shared by both DUTs
   logic [7:0]  c_mem   [4];
   logic [31:0] occ_mem [256];
   logic [7:0]  d_mem   [256];
   logic [1:0]  r_mem   [256];

   get_data_pipe_if #(.IDX_W(8), .ADDR_W(12), .CNT_W(8), .READ_W(2)) bus1 ();
   get_data_pipe_if #(.IDX_W(8), .ADDR_W(12), .CNT_W(8), .READ_W(2)) bus3 ();

   logic       ce1_C, ce1_O, ce1_D, ce3_C, ce3_O, ce3_D;
   logic [1:0] a1_C, a3_C;
   logic [7:0] a1_O1, a1_O2, a1_D, a3_O1, a3_O2, a3_D;
   logic [7:0]  r1_C, r1_di, r3_C, r3_di;
   logic [31:0] r1_d1, r1_d2, r3_d1, r3_d2;
   logic [1:0]  r1_rd, r3_rd;

   get_data_pipe #(.IDX_W(8), .ADDR_W(12), .CNT_W(8), .READ_W(2), .ROM_LAT(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave),
      .ce_rom_C(ce1_C), .addr_rom_C(a1_C), .ce_rom_Occ(ce1_O), .addr1_rom_Occ(a1_O1),
      .addr2_rom_Occ(a1_O2), .ce_rom_read_and_D(ce1_D), .addr_rom_read_and_D(a1_D),
      .data_C(r1_C), .data_1(r1_d1), .data_2(r1_d2), .d_i(r1_di), .read_i(r1_rd));

   get_data_pipe #(.IDX_W(8), .ADDR_W(12), .CNT_W(8), .READ_W(2), .ROM_LAT(3), .FIFO_DEPTH(4)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3.slave),
      .ce_rom_C(ce3_C), .addr_rom_C(a3_C), .ce_rom_Occ(ce3_O), .addr1_rom_Occ(a3_O1),
      .addr2_rom_Occ(a3_O2), .ce_rom_read_and_D(ce3_D), .addr_rom_read_and_D(a3_D),
      .data_C(r3_C), .data_1(r3_d1), .data_2(r3_d2), .d_i(r3_di), .read_i(r3_rd));

   // One-cycle ROMs for dut1
   always @(posedge clk) begin
      if (ce1_C) r1_C <= c_mem[a1_C];
      if (ce1_O) begin r1_d1 <= occ_mem[a1_O1]; r1_d2 <= occ_mem[a1_O2]; end
      if (ce1_D) begin r1_di <= d_mem[a1_D]; r1_rd <= r_mem[a1_D]; end
   end

   // Three-cycle ROMs for dut3
   logic [7:0]  p3_C [3], p3_di [3];
   logic [31:0] p3_d1 [3], p3_d2 [3];
   logic [1:0]  p3_rd [3];
   always @(posedge clk) begin
      if (ce3_C) p3_C[0] <= c_mem[a3_C];
      if (ce3_O) begin p3_d1[0] <= occ_mem[a3_O1]; p3_d2[0] <= occ_mem[a3_O2]; end
      if (ce3_D) begin p3_di[0] <= d_mem[a3_D]; p3_rd[0] <= r_mem[a3_D]; end
      for (int s = 1; s < 3; s++) begin
         p3_C[s] <= p3_C[s-1]; p3_d1[s] <= p3_d1[s-1]; p3_d2[s] <= p3_d2[s-1];
         p3_di[s] <= p3_di[s-1]; p3_rd[s] <= p3_rd[s-1];
      end
   end
   assign r3_C = p3_C[2]; assign r3_d1 = p3_d1[2]; assign r3_d2 = p3_d2[2];
   assign r3_di = p3_di[2]; assign r3_rd = p3_rd[2];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: ROM request expected for an accepted tuple
   function automatic logic [28:0] rom_exp(input logic [4:0] pos, input logic [7:0] i, k, l);
      logic [7:0] km1;
      rom_exp = '0;
      if (pos == 5'd0) rom_exp = {12'h0, 8'h0, 1'b1, i};
      else if (pos >= 5'd1 && pos <= 5'd4) begin
         km1 = k - 8'd1;
`ifdef GET_DATA_K0_GUARD_EN
         if (k == 8'd0) km1 = 8'd0;
`endif
         rom_exp = {1'b1, 2'(pos - 5'd1), 1'b1, km1, l, 9'h0};
      end
      else if (pos >= 5'd5 && pos <= 5'd8) rom_exp = {12'h0, 8'h0, 1'b1, i};
   endfunction

   // Reference: output record for an accepted tuple, from ROM contents
   function automatic out_t model(input logic [4:0] pos, input logic [7:0] i, z, k, l,
                                  input logic [11:0] addr);
      out_t o;
      int sym;
      o = '0;
      o.i = i; o.z = z; o.k = k; o.l = l; o.addr = addr; o.pos = pos;
      if (pos == 5'd0) o.di = d_mem[i];
      else if (pos >= 5'd1 && pos <= 5'd4) begin
         sym  = int'(pos) - 1;
         o.c  = c_mem[sym];
         o.d1 = 8'(occ_mem[8'(k - 8'd1)] >> (8 * sym));
         o.d2 = 8'(occ_mem[l] >> (8 * sym));
`ifdef GET_DATA_K0_GUARD_EN
         if (k == 8'd0) o.d1 = 8'h0;
`endif
      end
      else if (pos >= 5'd5 && pos <= 5'd8) o.rd = r_mem[i];
      return o;
   endfunction

   function automatic out_t cur_out();
      return {bus1.i_out, bus1.z_out, bus1.k_out, bus1.l_out, bus1.addr_out, bus1.position_out,
              bus1.C_out, bus1.data_1_out, bus1.data_2_out, bus1.d_i_out, bus1.read_i_out};
   endfunction

   function automatic logic [28:0] rom_act();
      return {ce1_C, a1_C, ce1_O, a1_O1, a1_O2, ce1_D, a1_D};
   endfunction

   // Monitor / scoreboard for dut1
   logic hold_pend = 1'b0;
   out_t hold_val;
   always @(negedge clk) begin
      if (rst) hold_pend = 1'b0;
      else begin
         if (hold_pend) begin
            chk("hold_valid", bus1.out_valid, 1);
            if (bus1.out_valid) chk("hold_data", cur_out(), hold_val);
         end
         hold_pend = bus1.out_valid && !bus1.out_ready;
         hold_val  = cur_out();
         if (bus1.in_valid && bus1.in_ready) begin
            chk("rom_req", rom_act(), rom_exp(bus1.position_in, bus1.i_in, bus1.k_in, bus1.l_in));
            exp_q.push_back(model(bus1.position_in, bus1.i_in, bus1.z_in, bus1.k_in, bus1.l_in,
                                  bus1.addr_in));
            n_acc++;
         end else chk("rom_idle", rom_act(), 0);
         if (bus1.out_valid && bus1.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out: got %0h expected no output", cur_out());
            end else chk("out_data", cur_out(), exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [4:0] pos, input logic [7:0] i, z, k, l, input logic [11:0] addr);
      int n = 0;
      bus1.in_valid = 1'b1; bus1.position_in = pos;
      bus1.i_in = i; bus1.z_in = z; bus1.k_in = k; bus1.l_in = l; bus1.addr_in = addr;
      @(negedge clk);
      while (!bus1.in_ready && n < 100) begin n++; @(negedge clk); end
      if (!bus1.in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
      end
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
   endtask

   task automatic send_rand();
      send(5'($urandom_range(0, 20)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom), 8'($urandom), 12'($urandom));
   endtask

   task automatic wait_out(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus1.out_valid && n < 20);
   endtask

   task automatic drain();
      int n = 0;
      bus1.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   logic stop_rdy;
   int   lat, acc0, out0;

   initial begin
      rst = 1'b1; stop_rdy = 1'b0;
      bus1.in_valid = 0; bus1.out_ready = 0; bus1.position_in = 0;
      bus1.i_in = 0; bus1.z_in = 0; bus1.k_in = 0; bus1.l_in = 0; bus1.addr_in = 0;
      bus3.in_valid = 0; bus3.out_ready = 0; bus3.position_in = 0;
      bus3.i_in = 0; bus3.z_in = 0; bus3.k_in = 0; bus3.l_in = 0; bus3.addr_in = 0;
      for (int a = 0; a < 256; a++) begin
         occ_mem[a] = $urandom; d_mem[a] = 8'($urandom); r_mem[a] = 2'($urandom);
      end
      for (int a = 0; a < 4; a++) c_mem[a] = 8'($urandom);

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus1.in_ready, 0);
      chk("rst_outs", {bus1.out_valid, cur_out()}, 0);
      chk("rst_rom", rom_act(), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", bus1.in_ready, 1);
      chk("post_rst_out_valid", bus1.out_valid, 0);
      @(posedge clk); #1;

      // C insertion, latency ROM_LAT+1
      occ_mem[4] = 32'h44332211; occ_mem[9] = 32'h88776655; c_mem[1] = 8'h10;
      bus1.out_ready = 1'b1;
      send(5'd2, 8'd3, 8'd1, 8'd5, 8'd9, 12'h123);
      wait_out(lat);
      chk("lat_rl1", lat, 2);
      chk("cins_d1", bus1.data_1_out, 8'h22);
      chk("cins_d2", bus1.data_2_out, 8'h66);
      chk("cins_c", bus1.C_out, 8'h10);
      @(posedge clk); #1;

      // backpressure: 6 offered, 4 accepted until output drains
      bus1.out_ready = 1'b0; acc0 = n_acc;
      fork
         for (int t = 0; t < 6; t++) send_rand();
         begin
            repeat (12) @(negedge clk);
            chk("bp_accepted", n_acc - acc0, 4);
            chk("bp_in_ready", bus1.in_ready, 0);
            @(posedge clk); #1 bus1.out_ready = 1'b1;
         end
      join
      chk("bp_all_accepted", n_acc - acc0, 6);
      drain();

      // insertion with k==0
      occ_mem[255] = 32'hA7B6C5D4; occ_mem[3] = 32'h01020304;
      send(5'd1, 8'd9, 8'd2, 8'd0, 8'd3, 12'h0AB);
      wait_out(lat);
`ifdef GET_DATA_K0_GUARD_EN
      chk("k0_d1", bus1.data_1_out, 8'h00);
`else
      chk("k0_d1", bus1.data_1_out, 8'hD4);
`endif
      chk("k0_d2", bus1.data_2_out, 8'h04);
      @(posedge clk); #1;

      // deletion then match, order kept
      r_mem[7] = 2'b10;
      bus1.out_ready = 1'b0;
      send(5'd7, 8'd7, 8'd4, 8'd20, 8'd30, 12'h777);
      send(5'd9, 8'd8, 8'd5, 8'd21, 8'd31, 12'h888);
      @(negedge clk);
      chk("del_read_i", bus1.read_i_out, 2);
      chk("del_d_i", bus1.d_i_out, 0);
      @(posedge clk); #1 bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("match_pos", bus1.position_out, 9);
      chk("match_fetched", {bus1.C_out, bus1.data_1_out, bus1.data_2_out, bus1.d_i_out,
                            bus1.read_i_out}, 0);
      @(posedge clk); #1;
      drain();

      // reset with tuples in flight
      send_rand(); send_rand(); send_rand();
      rst = 1'b1; exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", bus1.out_valid, 0);
      out0 = n_out;
      repeat (10) @(negedge clk);
      chk("flush_no_stale", n_out - out0, 0);
      @(posedge clk); #1;

      // randomized traffic with random backpressure
      for (int a = 0; a < 256; a++) begin
         occ_mem[a] = $urandom; d_mem[a] = 8'($urandom); r_mem[a] = 2'($urandom);
      end
      for (int a = 0; a < 4; a++) c_mem[a] = 8'($urandom);
      fork
         begin
            for (int t = 0; t < 150; t++) begin
               send_rand();
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            stop_rdy = 1'b1;
         end
         while (!stop_rdy) begin
            @(posedge clk); #1 bus1.out_ready = ($urandom_range(0, 3) != 0);
         end
      join
      drain();

      // ROM_LAT=3 instance: latency 4
      occ_mem[4] = 32'h44332211; occ_mem[9] = 32'h88776655; c_mem[1] = 8'h10;
      bus3.out_ready = 1'b1; bus3.position_in = 5'd2; bus3.k_in = 8'd5; bus3.l_in = 8'd9;
      bus3.i_in = 8'd3; bus3.z_in = 8'd1; bus3.addr_in = 12'h123; bus3.in_valid = 1'b1;
      lat = 0;
      @(negedge clk);
      while (!bus3.in_ready && lat < 50) begin lat++; @(negedge clk); end
      chk("rl3_accept", bus3.in_ready, 1);
      @(posedge clk); #1 bus3.in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus3.out_valid && lat < 20);
      chk("lat_rl3", lat, 4);
      chk("rl3_d1", bus3.data_1_out, 8'h22);
      chk("rl3_d2", bus3.data_2_out, 8'h66);
      chk("rl3_c", bus3.C_out, 8'h10);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
